// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encoding, grant constants and defaults for the memory bus arbiter
package mem_bus_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  localparam int DEF_TIMEOUT = 255;
  localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
  function automatic logic [1:0] onehot(input logic m);
    return m ? GNT_M1 : GNT_M0;
  endfunction
endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: picorv32-style native valid/ready memory bus
interface mem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic valid;
  logic instr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic ready;
  logic [DATA_W-1:0] rdata;
  modport master(output valid, instr, addr, wdata, wstrb, input ready, rdata);
  modport slave(input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// arb_watchdog: saturating stall counter that flags the last allowed cycle before expiry
module arb_watchdog #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : (en_i && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
  assign expire_o = en_i && cnt_q == W'(MAX - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master arbiter for a single valid/ready slave with stall watchdog
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(DEF_ERR_RDATA)
) (
  input  logic       clk,
  input  logic       resetn,
  mem_bus_if.slave   m0,
  mem_bus_if.slave   m1,
  mem_bus_if.master  s,
  output logic [1:0] grant,
  output logic       timeout_err
);
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic prio_q, prio_d, exp_q, exp_d;
  logic busy, sel, gv, done, expire;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] rdata_mux;
  assign busy = state_q == ST_BUSY;
  assign sel = grant_q[1];
  assign gv = busy && (sel ? m1.valid : m0.valid);
  // exp_q marks the registered forced-completion cycle after the watchdog fired
  assign done = busy && (exp_q || (gv && s.ready));
  arb_watchdog #(.MAX(TIMEOUT)) u_wdog (
    .clk,
    .resetn,
    .clr_i(!busy),
    .en_i(gv && !s.ready && !exp_q),
    .expire_o(expire)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d = prio_q;
    exp_d = 1'b0;
    if (!busy) begin
      grant_d = (m0.valid && m1.valid) ? onehot(prio_q) : m1.valid ? GNT_M1 : m0.valid ? GNT_M0 : GNT_NONE;
      state_d = (m0.valid || m1.valid) ? ST_BUSY : ST_IDLE;
    end else if (done || !gv) begin
      state_d = ST_IDLE;
      grant_d = GNT_NONE;
      prio_d = done ? !sel : prio_q;
    end else begin
      exp_d = expire;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
      prio_q <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q <= prio_d;
      exp_q <= exp_d;
    end
  assign addr_mux = sel ? m1.addr : m0.addr;
  assign s.addr = addr_mux;
  assign s.valid = gv && !exp_q;
  assign s.instr = sel ? m1.instr : m0.instr;
  assign s.wdata = sel ? m1.wdata : m0.wdata;
  assign s.wstrb = sel ? m1.wstrb : m0.wstrb;
  assign rdata_mux = exp_q ? ERR_RDATA : s.rdata;
  assign m0.ready = done && !sel;
  assign m1.ready = done && sel;
  assign m0.rdata = m0.ready ? rdata_mux : '0;
  assign m1.rdata = m1.ready ? rdata_mux : '0;
  assign grant = grant_q;
  assign timeout_err = exp_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scoreboard bench for the two-master memory bus arbiter
module tb_mem_bus_arbiter;
  localparam int TMO = 8;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic instr;
    int abort;
  } req_t;
  typedef struct {
    logic [31:0] rdata;
    logic tmo;
    int cyc;
  } exp_t;
  logic clk, resetn;
  logic [1:0] grant;
  logic timeout_err;
  logic mv[2], mi[2], mr[2];
  logic [31:0] ma[2], mw[2], mrd[2];
  logic [3:0] ms[2];
  logic sr;
  logic [31:0] srd;
  int npass = 0, ntot = 0;
  int lat = 1;
  bit never = 0;
  logic [15:0] ord = '0;
  int nd = 0;
  req_t rq[2][$];
  exp_t expq[2][$];
  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) m0_if();
  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) m1_if();
  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) s_if();
  assign m0_if.valid = mv[0];
  assign m0_if.instr = mi[0];
  assign m0_if.addr = ma[0];
  assign m0_if.wdata = mw[0];
  assign m0_if.wstrb = ms[0];
  assign m1_if.valid = mv[1];
  assign m1_if.instr = mi[1];
  assign m1_if.addr = ma[1];
  assign m1_if.wdata = mw[1];
  assign m1_if.wstrb = ms[1];
  assign mr[0] = m0_if.ready;
  assign mr[1] = m1_if.ready;
  assign mrd[0] = m0_if.rdata;
  assign mrd[1] = m1_if.rdata;
  assign s_if.ready = sr;
  assign s_if.rdata = srd;
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk),
    .resetn(resetn),
    .m0(m0_if),
    .m1(m1_if),
    .s(s_if),
    .grant(grant),
    .timeout_err(timeout_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic push(input int m, input logic [31:0] a, input logic [31:0] w, input logic [3:0] st,
                      input logic ins, input int ab);
    req_t r;
    r.addr = a;
    r.wdata = w;
    r.wstrb = st;
    r.instr = ins;
    r.abort = ab;
    rq[m].push_back(r);
  endtask
  task automatic wait_done();
    int k = 0;
    while ((rq[0].size() != 0 || rq[1].size() != 0 || expq[0].size() != 0 || expq[1].size() != 0 ||
            mv[0] || mv[1]) && k < 400) begin
      @(posedge clk);
      k++;
    end
    chk("drain_wait", {31'd0, k < 400}, 32'd1);
    repeat (2) @(posedge clk);
  endtask
  task automatic master_proc(input int m);
    req_t r;
    exp_t e;
    int k;
    forever begin
      @(posedge clk);
      #1;
      while (rq[m].size() != 0) begin
        r = rq[m].pop_front();
        mv[m] = 1'b1;
        ma[m] = r.addr;
        mw[m] = r.wdata;
        ms[m] = r.wstrb;
        mi[m] = r.instr;
        if (r.abort != 0) begin
          repeat (r.abort) @(posedge clk);
          #1;
          mv[m] = 1'b0;
        end else begin
          e.rdata = never ? 32'hDEAD_BEEF : f(r.addr);
          e.tmo = never;
          e.cyc = never ? TMO + 1 : lat + 1;
          expq[m].push_back(e);
          k = 0;
          @(negedge clk);
          while (!mr[m] && k < 100) begin
            k++;
            @(negedge clk);
          end
          chk("ready_wait", {31'd0, k < 100}, 32'd1);
          @(posedge clk);
          #1;
        end
      end
      mv[m] = 1'b0;
    end
  endtask
  initial master_proc(0);
  initial master_proc(1);
  initial begin
    int cnt = 0;
    sr = 1'b0;
    srd = '0;
    forever begin
      @(posedge clk);
      #1;
      sr = 1'b0;
      if (s_if.valid && !never) begin
        if (cnt >= lat) begin
          sr = 1'b1;
          srd = f(s_if.addr);
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end
  initial begin
    int bc = 0;
    bit pab = 0;
    logic s;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bc = 0;
        pab = 0;
        continue;
      end
      bc = (grant != 2'b00) ? bc + 1 : 0;
      if (pab) chk("abort_idle", {30'd0, grant}, 32'd0);
      s = grant[1];
      pab = grant != 2'b00 && !mv[s] && !timeout_err;
      if (pab) chk("abort_svalid", {31'd0, s_if.valid}, 32'd0);
      if (timeout_err) chk("tmo_svalid", {31'd0, s_if.valid}, 32'd0);
      if (s_if.valid) begin
        chk("s_grant", {30'd0, grant}, s ? 32'd2 : 32'd1);
        chk("s_addr", s_if.addr, ma[s]);
        chk("s_wdata", s_if.wdata, mw[s]);
        chk("s_wstrb", {28'd0, s_if.wstrb}, {28'd0, ms[s]});
        chk("s_instr", {31'd0, s_if.instr}, {31'd0, mi[s]});
        chk("ng_ready", {31'd0, mr[!s]}, 32'd0);
        chk("ng_rdata", mrd[!s], 32'd0);
      end
      for (int m = 0; m < 2; m++) begin
        if (mr[m]) begin
          if (expq[m].size() == 0) chk("unexp_ready", 32'd1, 32'd0);
          else begin
            e = expq[m].pop_front();
            chk("rdata", mrd[m], e.rdata);
            chk("tmo_flag", {31'd0, timeout_err}, {31'd0, e.tmo});
            chk("rdy_grant", {30'd0, grant}, m == 1 ? 32'd2 : 32'd1);
            chk("rdy_cycles", bc, e.cyc);
            chk("other_ready", {31'd0, mr[1-m]}, 32'd0);
            ord = {ord[14:0], m[0]};
            nd++;
          end
        end
      end
      if (!mr[0] && !mr[1]) chk("tmo_quiet", {31'd0, timeout_err}, 32'd0);
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    resetn = 1'b0;
    mv[0] = 0; mv[1] = 0; mi[0] = 0; mi[1] = 0;
    ma[0] = '0; ma[1] = '0; mw[0] = '0; mw[1] = '0; ms[0] = '0; ms[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_svalid", {31'd0, s_if.valid}, 32'd0);
    chk("rst_m0_ready", {31'd0, mr[0]}, 32'd0);
    chk("rst_m1_ready", {31'd0, mr[1]}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    chk("rst_m0_rdata", mrd[0], 32'd0);
    chk("rst_m1_rdata", mrd[1], 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ord = '0; nd = 0;
    push(0, 32'h0000_0200, 32'h0, 4'h0, 1'b1, 0);
    push(0, 32'h0000_0204, 32'h0, 4'h0, 1'b1, 0);
    push(1, 32'h2000_0000, 32'hAAAA_0001, 4'h3, 1'b0, 0);
    push(1, 32'h2000_0004, 32'hAAAA_0002, 4'hC, 1'b0, 0);
    wait_done();
    chk("t2_order", {16'd0, ord}, 32'b0101);
    chk("t2_count", nd, 32'd4);
    ord = '0; nd = 0;
    push(0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 0);
    wait_done();
    chk("t1_order", {16'd0, ord}, 32'd0);
    chk("t1_count", nd, 32'd1);
    ord = '0; nd = 0;
    push(0, 32'h0000_0300, 32'h0, 4'h0, 1'b0, 0);
    push(1, 32'h2000_0300, 32'h0, 4'h0, 1'b0, 0);
    wait_done();
    chk("prio_m1_order", {16'd0, ord}, 32'b10);
    chk("prio_m1_count", nd, 32'd2);
    ord = '0; nd = 0;
    push(1, 32'h1000_0008, 32'h0000_1234, 4'hF, 1'b0, 0);
    wait_done();
    chk("t3_order", {16'd0, ord}, 32'd1);
    chk("t3_count", nd, 32'd1);
    ord = '0; nd = 0;
    never = 1'b1;
    push(0, 32'h0000_0400, 32'h0, 4'h0, 1'b0, 0);
    wait_done();
    never = 1'b0;
    push(0, 32'h0000_0404, 32'h0, 4'h0, 1'b0, 0);
    wait_done();
    chk("t4_order", {16'd0, ord}, 32'd0);
    chk("t4_count", nd, 32'd2);
    ord = '0; nd = 0;
    push(1, 32'h2000_0500, 32'h0, 4'h0, 1'b0, 0);
    wait_done();
    lat = 5;
    push(0, 32'h0000_0600, 32'h0, 4'h0, 1'b0, 3);
    wait_done();
    lat = 1;
    push(1, 32'h2000_0604, 32'h0, 4'h0, 1'b0, 0);
    push(0, 32'h0000_0604, 32'h0, 4'h0, 1'b0, 0);
    wait_done();
    chk("t6_order", {16'd0, ord}, 32'b101);
    chk("t6_count", nd, 32'd3);
    ord = '0; nd = 0;
    never = 1'b1;
    push(0, 32'h0000_0700, 32'h0, 4'h0, 1'b0, 10);
    repeat (4) @(posedge clk);
    #3;
    chk("t5_busy_grant", {30'd0, grant}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t5_svalid", {31'd0, s_if.valid}, 32'd0);
    chk("t5_grant", {30'd0, grant}, 32'd0);
    chk("t5_m0_ready", {31'd0, mr[0]}, 32'd0);
    chk("t5_m1_ready", {31'd0, mr[1]}, 32'd0);
    chk("t5_tmo", {31'd0, timeout_err}, 32'd0);
    never = 1'b0;
    push(1, 32'h2000_0800, 32'h0, 4'h0, 1'b1, 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    wait_done();
    chk("t5_order", {16'd0, ord}, 32'd1);
    chk("t5_count", nd, 32'd1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
